cp0_exception_commit: RTL and testbench
=======================================

// Module: cp0_exception_commit
// PURPOSE
//  Downstream consumer of the MEM-stage exception block. Holds CP0 Status/Cause/EPC/BadVAddr/Count/Compare.
//  On a committed exception/eret it updates CP0 state and emits the redirect PC to NPC logic.
//  Feeds back Status IM/EXL/IE and Cause IP bits for the interrupt check in MEM.
// PARAMETERS
//  VEC_BEV1     32'hBFC0_0380  general exception vector when Status.BEV=1
//  VEC_BEV0     32'h8000_0180  general exception vector when Status.BEV=0
//  REFILL_OFS   32'h0000_0180  refill vector = general vector - REFILL_OFS
//  COUNT_DIV    2              Count increments once every COUNT_DIV cycles
// PORTS
//  clk                input   1   clock
//  rst                input   1   async active-low reset
//  MEM_ExceptType_final input ExceptinPipeType  final exception vector from MEM
//  EX_Entry_Sel       input   3   IsNone/IsException/IsRefill/IsEret/IsRefetch
//  MEM_PC             input   32  PC of MEM instruction
//  MEM_IsInDelaySlot  input   1   MEM instruction is in a branch delay slot
//  MEM_BadVAddr       input   32  data virtual address of MEM load/store
//  MEM_Stall          input   1   MEM held; no CP0 state update this cycle
//  MEM_CP0We          input   1   MTC0 commit
//  MEM_CP0Addr        input   5   CP0 register number (sel 0 only)
//  MEM_CP0Wdata       input   32  MTC0 data
//  CP0_RdAddr         input   5   MFC0 read address
//  Ext_Int            input   6   hardware interrupt lines HW5..HW0
//  CP0_RdData         output  32  MFC0 data, combinational; unmapped addr -> 0
//  CP0_Status_IM7_0   output  8   Status[15:8]
//  CP0_Status_EXL     output  1   Status[1]
//  CP0_Status_IE      output  1   Status[0]
//  CP0_Cause_IP7_2    output  6   Cause[15:10]
//  CP0_Cause_IP1_0    output  2   Cause[9:8]
//  EX_TargetPC        output  32  redirect PC, valid when EX_Entry_Sel != IsNone
// BEHAVIOUR
//  Reset: Status=32'h0040_0000 (BEV=1), Cause=EPC=BadVAddr=Count=Compare=0, tick divider=0, TI=0.
//  Writable bits: Status BEV[22], IM[15:8], EXL[1], IE[0]; Cause IP1_0[9:8]; EPC/Count/Compare all bits.
//  BadVAddr read-only.
//  Cause.IP7_2 <= {Ext_Int[5]|TI, Ext_Int[4:0]} every cycle, independent of MEM_Stall.
//  Timer: Count += 1 when divider wraps.
//  TI set when Count==Compare after update; sticky; cleared only by MTC0 Compare.
//  Priority: MTC0 Count beats tick in the same cycle.
//  Commit happens only when !MEM_Stall; otherwise all state except Count/IP/TI is held.
//  IsException/IsRefill:
//   - if EXL==0: EPC<=BD?MEM_PC-4:MEM_PC and Cause.BD<=MEM_IsInDelaySlot
//   - always: EXL<=1; ExcCode per priority below
//   - any pending MTC0 in the same cycle is discarded (exception wins)
//  ExcCode priority (high->low):
//   Interrupt 0x00 > WrongAddressinIF AdEL 0x04 > TLBRefill/InvalidinIF TLBL 0x02 > RI 0x0a
//   > Syscall 0x08 > Break 0x09 > Trap 0x0d > Overflow 0x0c > RdWrongAddr AdEL 0x04
//   > WrWrongAddr AdES 0x05 > RdTLB* TLBL 0x02 > WrTLB* TLBS 0x03 > TLBModified Mod 0x01.
//  BadVAddr: IF-side address/TLB cause -> MEM_PC; MEM-side -> MEM_BadVAddr; otherwise unchanged.
//  IsEret: EXL<=0, EX_TargetPC=EPC. IsRefetch: no CP0 change, EX_TargetPC=MEM_PC+4.
//  EX_TargetPC:
//   - IsException: BEV vector
//   - IsRefill: vector-REFILL_OFS if EXL==0, else general vector
//   - IsNone: 0
//   - computed from pre-update register values
//  Next-cycle MFC0 sees values updated this cycle; no same-cycle bypass.
// STRUCTURE
//  Shared package: ExcCode constants, CP0 register numbers (BadVAddr 8, Count 9, Compare 11,
//  Status 12, Cause 13, EPC 14), Status/Cause bit positions.
//  Sub-module cp0_timer: divider, Count, Compare, TI; write ports from top.
// TESTING
//  Reset mid-run: assert rst with Count=5 -> all regs 0, Status=32'h0040_0000, next cycle.
//  Syscall at PC=32'h8000_1000, BD=1, EXL=0 -> EPC=32'h8000_0FFC, Cause.BD=1, ExcCode=0x08,
//   EXL=1, TargetPC=32'hBFC0_0380.
//  Status BEV=0 and EXL=0, RdTLBRefillinMEM addr 32'h0040_0010 -> TargetPC=32'h8000_0000,
//   BadVAddr=32'h0040_0010, ExcCode=0x02.
//  Exception with MEM_Stall=1 for 3 cycles -> no CP0 change until stall drops, then single update.
//  Compare=3, Count=0, COUNT_DIV=2 -> Cause.IP7=1 one cycle after Count reaches 3;
//   MTC0 Compare clears it.
//  Eret after exception, EPC=32'h8000_2000 -> TargetPC=32'h8000_2000, EXL=0.
//  Eret coincident with MTC0 Status -> exception path wins, Status write dropped.

Source files
------------

// File: rtl/cp0_exception_commit_pkg.sv
`default_nettype none
// ============================================================================
// cp0_exception_commit_pkg : shared CP0 types, register numbers, ExcCodes
// Rev 1.0 - initial release
// ============================================================================
package cp0_exception_commit_pkg;

    typedef enum logic [2:0] {
        IsNone      = 3'd0,
        IsException = 3'd1,
        IsRefill    = 3'd2,
        IsEret      = 3'd3,
        IsRefetch   = 3'd4
    } entry_sel_e;

    typedef struct packed {
        logic Interrupt;
        logic WrongAddressinIF;
        logic TLBRefillinIF;
        logic TLBInvalidinIF;
        logic RI;
        logic Syscall;
        logic Break;
        logic Trap;
        logic Overflow;
        logic RdWrongAddressinMEM;
        logic WrWrongAddressinMEM;
        logic RdTLBRefillinMEM;
        logic RdTLBInvalidinMEM;
        logic WrTLBRefillinMEM;
        logic WrTLBInvalidinMEM;
        logic TLBModified;
    } ExceptinPipeType;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_MOD  = 5'h01;
    localparam logic [4:0] EXC_TLBL = 5'h02;
    localparam logic [4:0] EXC_TLBS = 5'h03;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;
    localparam logic [4:0] EXC_TR   = 5'h0d;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam int          STATUS_BEV   = 22;
    localparam int          STATUS_EXL   = 1;
    localparam int          STATUS_IE    = 0;
    localparam logic [31:0] STATUS_WMASK = 32'h0040_FF03;
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;

    typedef struct packed {
        logic [4:0] code;
        logic       bad_pc;
        logic       bad_mem;
    } exc_info_t;

    // Highest-priority cause wins; it alone decides where BadVAddr comes from.
    function automatic exc_info_t exc_decode(input ExceptinPipeType e);
        exc_info_t r;
        r = '{code: EXC_INT, bad_pc: 1'b0, bad_mem: 1'b0};
        if (e.Interrupt)                                 r.code = EXC_INT;
        else if (e.WrongAddressinIF)                     begin r.code = EXC_ADEL; r.bad_pc = 1'b1; end
        else if (e.TLBRefillinIF || e.TLBInvalidinIF)    begin r.code = EXC_TLBL; r.bad_pc = 1'b1; end
        else if (e.RI)                                   r.code = EXC_RI;
        else if (e.Syscall)                              r.code = EXC_SYS;
        else if (e.Break)                                r.code = EXC_BP;
        else if (e.Trap)                                 r.code = EXC_TR;
        else if (e.Overflow)                             r.code = EXC_OV;
        else if (e.RdWrongAddressinMEM)                  begin r.code = EXC_ADEL; r.bad_mem = 1'b1; end
        else if (e.WrWrongAddressinMEM)                  begin r.code = EXC_ADES; r.bad_mem = 1'b1; end
        else if (e.RdTLBRefillinMEM || e.RdTLBInvalidinMEM) begin r.code = EXC_TLBL; r.bad_mem = 1'b1; end
        else if (e.WrTLBRefillinMEM || e.WrTLBInvalidinMEM) begin r.code = EXC_TLBS; r.bad_mem = 1'b1; end
        else if (e.TLBModified)                          begin r.code = EXC_MOD; r.bad_mem = 1'b1; end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_exception_commit_timer.sv
`default_nettype none
// ============================================================================
// cp0_timer : Count/Compare pair with prescaler and sticky timer interrupt
// Rev 1.0 - initial release
// ============================================================================
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_count_we,
    input  logic        i_compare_we,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_count,
    output logic [31:0] o_compare,
    output logic        o_ti
);
    localparam int               DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [31:0]      r_count;
    logic [31:0]      r_compare;
    logic             r_ti;
    logic             w_tick;
    logic [31:0]      w_count_nxt;

    assign w_tick      = (r_div == DIV_LAST);
    assign w_count_nxt = i_count_we ? i_wdata : (w_tick ? r_count + 32'd1 : r_count);

    // TI only arms on an actual Count update, so Count==Compare==0 after reset stays quiet.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_count   <= '0;
            r_compare <= '0;
            r_ti      <= 1'b0;
        end else begin
            r_div   <= w_tick ? '0 : r_div + DIV_W'(1);
            r_count <= w_count_nxt;
            if (i_compare_we) begin
                r_compare <= i_wdata;
                r_ti      <= 1'b0;
            end else if ((i_count_we || w_tick) && (w_count_nxt == r_compare)) begin
                r_ti <= 1'b1;
            end
        end
    end

    assign o_count   = r_count;
    assign o_compare = r_compare;
    assign o_ti      = r_ti;
endmodule
`default_nettype wire

// File: rtl/cp0_exception_commit.sv
`default_nettype none
// ============================================================================
// cp0_exception_commit : CP0 state, exception/eret commit and redirect PC
// Rev 1.0 - initial release
// ============================================================================
module cp0_exception_commit
    import cp0_exception_commit_pkg::*;
#(
    parameter logic [31:0] VEC_BEV1   = 32'hBFC0_0380,
    parameter logic [31:0] VEC_BEV0   = 32'h8000_0180,
    parameter logic [31:0] REFILL_OFS = 32'h0000_0180,
    parameter int          COUNT_DIV  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  ExceptinPipeType MEM_ExceptType_final,
    input  logic [2:0]      EX_Entry_Sel,
    input  logic [31:0]     MEM_PC,
    input  logic            MEM_IsInDelaySlot,
    input  logic [31:0]     MEM_BadVAddr,
    input  logic            MEM_Stall,
    input  logic            MEM_CP0We,
    input  logic [4:0]      MEM_CP0Addr,
    input  logic [31:0]     MEM_CP0Wdata,
    input  logic [4:0]      CP0_RdAddr,
    input  logic [5:0]      Ext_Int,
    output logic [31:0]     CP0_RdData,
    output logic [7:0]      CP0_Status_IM7_0,
    output logic            CP0_Status_EXL,
    output logic            CP0_Status_IE,
    output logic [5:0]      CP0_Cause_IP7_2,
    output logic [1:0]      CP0_Cause_IP1_0,
    output logic [31:0]     EX_TargetPC
);
    logic [31:0] r_status;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip7_2;
    logic [1:0]  r_cause_ip1_0;
    logic [4:0]  r_cause_exc;
    logic [31:0] r_epc;
    logic [31:0] r_badvaddr;

    logic [31:0] w_count;
    logic [31:0] w_compare;
    logic        w_ti;
    logic        w_exc_take;
    logic        w_eret_take;
    logic        w_mtc0;
    logic [31:0] w_gen_vec;
    exc_info_t   w_info;

    // Any redirect in the same cycle cancels a pending MTC0.
    assign w_exc_take  = !MEM_Stall && (EX_Entry_Sel == IsException || EX_Entry_Sel == IsRefill);
    assign w_eret_take = !MEM_Stall && (EX_Entry_Sel == IsEret);
    assign w_mtc0      = !MEM_Stall && MEM_CP0We && (EX_Entry_Sel == IsNone);
    assign w_info      = exc_decode(MEM_ExceptType_final);
    assign w_gen_vec   = r_status[STATUS_BEV] ? VEC_BEV1 : VEC_BEV0;

    cp0_timer #(
        .COUNT_DIV    (COUNT_DIV)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .i_count_we   (w_mtc0 && (MEM_CP0Addr == REG_COUNT)),
        .i_compare_we (w_mtc0 && (MEM_CP0Addr == REG_COMPARE)),
        .i_wdata      (MEM_CP0Wdata),
        .o_count      (w_count),
        .o_compare    (w_compare),
        .o_ti         (w_ti)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_status      <= STATUS_RESET;
            r_cause_bd    <= 1'b0;
            r_cause_ip7_2 <= '0;
            r_cause_ip1_0 <= '0;
            r_cause_exc   <= '0;
            r_epc         <= '0;
            r_badvaddr    <= '0;
        end else begin
            r_cause_ip7_2 <= {Ext_Int[5] | w_ti, Ext_Int[4:0]};
            if (w_exc_take) begin
                if (!r_status[STATUS_EXL]) begin
                    r_epc      <= MEM_IsInDelaySlot ? MEM_PC - 32'd4 : MEM_PC;
                    r_cause_bd <= MEM_IsInDelaySlot;
                end
                r_status[STATUS_EXL] <= 1'b1;
                r_cause_exc          <= w_info.code;
                if (w_info.bad_pc)
                    r_badvaddr <= MEM_PC;
                else if (w_info.bad_mem)
                    r_badvaddr <= MEM_BadVAddr;
            end else if (w_eret_take) begin
                r_status[STATUS_EXL] <= 1'b0;
            end else if (w_mtc0) begin
                case (MEM_CP0Addr)
                    REG_STATUS: r_status      <= (r_status & ~STATUS_WMASK) | (MEM_CP0Wdata & STATUS_WMASK);
                    REG_CAUSE:  r_cause_ip1_0 <= MEM_CP0Wdata[9:8];
                    REG_EPC:    r_epc         <= MEM_CP0Wdata;
                    default:    ;
                endcase
            end
        end
    end

    always_comb begin
        CP0_RdData = '0;
        case (CP0_RdAddr)
            REG_BADVADDR: CP0_RdData = r_badvaddr;
            REG_COUNT:    CP0_RdData = w_count;
            REG_COMPARE:  CP0_RdData = w_compare;
            REG_STATUS:   CP0_RdData = r_status;
            REG_CAUSE:    CP0_RdData = {r_cause_bd, 15'd0, r_cause_ip7_2, r_cause_ip1_0,
                                        1'b0, r_cause_exc, 2'b00};
            REG_EPC:      CP0_RdData = r_epc;
            default:      CP0_RdData = '0;
        endcase
    end

    always_comb begin
        EX_TargetPC = '0;
        case (entry_sel_e'(EX_Entry_Sel))
            IsException: EX_TargetPC = w_gen_vec;
            IsRefill:    EX_TargetPC = r_status[STATUS_EXL] ? w_gen_vec : w_gen_vec - REFILL_OFS;
            IsEret:      EX_TargetPC = r_epc;
            IsRefetch:   EX_TargetPC = MEM_PC + 32'd4;
            default:     EX_TargetPC = '0;
        endcase
    end

    assign CP0_Status_IM7_0 = r_status[15:8];
    assign CP0_Status_EXL   = r_status[STATUS_EXL];
    assign CP0_Status_IE    = r_status[STATUS_IE];
    assign CP0_Cause_IP7_2  = r_cause_ip7_2;
    assign CP0_Cause_IP1_0  = r_cause_ip1_0;
endmodule
`default_nettype wire

// File: tb/tb_cp0_exception_commit.sv
`default_nettype none
// ============================================================================
// tb_cp0_exception_commit : directed stimulus with queued expectations
// Rev 1.0 - initial release
// ============================================================================
module tb_cp0_exception_commit;
    import cp0_exception_commit_pkg::*;

    localparam int K_TGT = 0;
    localparam int K_RD  = 1;
    localparam int K_IP  = 2;
    localparam int K_EXL = 3;

    typedef struct {
        int          tag;
        int          kind;
        logic [31:0] v;
        bit [127:0]  name;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    ExceptinPipeType exc;
    logic [2:0]      EX_Entry_Sel;
    logic [31:0]     MEM_PC;
    logic            MEM_IsInDelaySlot;
    logic [31:0]     MEM_BadVAddr;
    logic            MEM_Stall;
    logic            MEM_CP0We;
    logic [4:0]      MEM_CP0Addr;
    logic [31:0]     MEM_CP0Wdata;
    logic [4:0]      CP0_RdAddr;
    logic [5:0]      Ext_Int;
    logic [31:0]     CP0_RdData;
    logic [7:0]      CP0_Status_IM7_0;
    logic            CP0_Status_EXL;
    logic            CP0_Status_IE;
    logic [5:0]      CP0_Cause_IP7_2;
    logic [1:0]      CP0_Cause_IP1_0;
    logic [31:0]     EX_TargetPC;

    cp0_exception_commit dut (
        .clk                  (clk),
        .rst                  (rst),
        .MEM_ExceptType_final (exc),
        .EX_Entry_Sel         (EX_Entry_Sel),
        .MEM_PC               (MEM_PC),
        .MEM_IsInDelaySlot    (MEM_IsInDelaySlot),
        .MEM_BadVAddr         (MEM_BadVAddr),
        .MEM_Stall            (MEM_Stall),
        .MEM_CP0We            (MEM_CP0We),
        .MEM_CP0Addr          (MEM_CP0Addr),
        .MEM_CP0Wdata         (MEM_CP0Wdata),
        .CP0_RdAddr           (CP0_RdAddr),
        .Ext_Int              (Ext_Int),
        .CP0_RdData           (CP0_RdData),
        .CP0_Status_IM7_0     (CP0_Status_IM7_0),
        .CP0_Status_EXL       (CP0_Status_EXL),
        .CP0_Status_IE        (CP0_Status_IE),
        .CP0_Cause_IP7_2      (CP0_Cause_IP7_2),
        .CP0_Cause_IP1_0      (CP0_Cause_IP1_0),
        .EX_TargetPC          (EX_TargetPC)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: at each falling edge, compare every expectation tagged for this cycle.
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].tag <= cyc) begin
                e = sb.pop_front();
                case (e.kind)
                    K_TGT:   act = EX_TargetPC;
                    K_RD:    act = CP0_RdData;
                    K_IP:    act = {26'd0, CP0_Cause_IP7_2};
                    default: act = {31'd0, CP0_Status_EXL};
                endcase
                total++;
                if (e.tag != cyc) begin
                    bad++;
                    $display("FAIL %0s stale check got=%h want=%h", e.name, act, e.v);
                end else if (act !== e.v) begin
                    bad++;
                    $display("FAIL %0s got=%h want=%h", e.name, act, e.v);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int k, input logic [31:0] v, input bit [127:0] n);
        exp_t e;
        e.tag  = cyc;
        e.kind = k;
        e.v    = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic idle();
        EX_Entry_Sel      = IsNone;
        exc               = '0;
        MEM_Stall         = 1'b0;
        MEM_CP0We         = 1'b0;
        MEM_IsInDelaySlot = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] v, input bit [127:0] n);
        CP0_RdAddr = a;
        push(K_RD, v, n);
        tick();
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        MEM_CP0We    = 1'b1;
        MEM_CP0Addr  = a;
        MEM_CP0Wdata = d;
        tick();
        MEM_CP0We    = 1'b0;
    endtask

    task automatic entry(input logic [2:0] sel, input logic [31:0] pc, input logic bd,
                         input logic [31:0] tgt, input bit [127:0] n);
        EX_Entry_Sel      = sel;
        MEM_PC            = pc;
        MEM_IsInDelaySlot = bd;
        push(K_TGT, tgt, n);
        tick();
        idle();
    endtask

    initial begin
        idle();
        MEM_PC = '0; MEM_BadVAddr = '0; MEM_CP0Addr = '0; MEM_CP0Wdata = '0;
        CP0_RdAddr = '0; Ext_Int = '0;
        repeat (3) tick();
        rst = 1'b1;

        rd(REG_COUNT,    32'h0,          "rst_count");
        rd(REG_STATUS,   32'h0040_0000,  "rst_status");
        rd(REG_CAUSE,    32'h0,          "rst_cause");
        rd(REG_EPC,      32'h0,          "rst_epc");
        rd(REG_BADVADDR, 32'h0,          "rst_badva");
        rd(REG_COMPARE,  32'h0,          "rst_compare");
        push(K_EXL, 32'h0, "rst_exl");
        push(K_IP,  32'h0, "rst_ip");
        rd(5'd5,         32'h0,          "unmapped");

        // Syscall in a delay slot with BEV=1
        exc.Syscall = 1'b1;
        entry(IsException, 32'h8000_1000, 1'b1, 32'hBFC0_0380, "sys_tgt");
        push(K_EXL, 32'h1, "sys_exl");
        rd(REG_EPC,    32'h8000_0FFC, "sys_epc");
        rd(REG_CAUSE,  32'h8000_0020, "sys_cause");
        rd(REG_STATUS, 32'h0040_0002, "sys_status");

        mtc0(REG_EPC, 32'h8000_2000);
        entry(IsEret, 32'h0, 1'b0, 32'h8000_2000, "eret_tgt");
        rd(REG_STATUS, 32'h0040_0000, "eret_status");

        // Eret and MTC0 Status in the same cycle: the write must vanish
        MEM_CP0We = 1'b1; MEM_CP0Addr = REG_STATUS; MEM_CP0Wdata = 32'h0000_FF01;
        entry(IsEret, 32'h0, 1'b0, 32'h8000_2000, "eretmtc0_tgt");
        rd(REG_STATUS, 32'h0040_0000, "eretmtc0_drop");

        // BEV=0 refill, first with EXL=0 then nested with EXL=1
        mtc0(REG_STATUS, 32'h0);
        rd(REG_STATUS, 32'h0, "bev0_status");
        exc.RdTLBRefillinMEM = 1'b1; MEM_BadVAddr = 32'h0040_0010;
        entry(IsRefill, 32'h8000_3000, 1'b0, 32'h8000_0000, "refill_tgt");
        rd(REG_BADVADDR, 32'h0040_0010, "refill_badva");
        rd(REG_CAUSE,    32'h0000_0008, "refill_cause");
        rd(REG_EPC,      32'h8000_3000, "refill_epc");
        rd(REG_STATUS,   32'h0000_0002, "refill_status");
        exc.WrTLBRefillinMEM = 1'b1; MEM_BadVAddr = 32'h1234_5678;
        entry(IsRefill, 32'h8000_4000, 1'b1, 32'h8000_0180, "refillx_tgt");
        rd(REG_CAUSE,    32'h0000_000C, "refillx_cause");
        rd(REG_EPC,      32'h8000_3000, "refillx_epc");
        rd(REG_BADVADDR, 32'h1234_5678, "refillx_badva");
        entry(IsEret, 32'h0, 1'b0, 32'h8000_3000, "eret2_tgt");

        // ExcCode priority
        exc.RI = 1'b1; exc.Overflow = 1'b1; exc.WrWrongAddressinMEM = 1'b1;
        MEM_BadVAddr = 32'hDEAD_0000;
        entry(IsException, 32'h8000_5000, 1'b0, 32'h8000_0180, "ri_tgt");
        rd(REG_CAUSE,    32'h0000_0028, "prio_ri");
        rd(REG_BADVADDR, 32'h1234_5678, "prio_ri_badva");
        rd(REG_EPC,      32'h8000_5000, "prio_ri_epc");
        exc.WrongAddressinIF = 1'b1; exc.Syscall = 1'b1;
        entry(IsException, 32'h8000_6001, 1'b0, 32'h8000_0180, "adel_tgt");
        rd(REG_CAUSE,    32'h0000_0010, "prio_adel");
        rd(REG_BADVADDR, 32'h8000_6001, "prio_adel_badva");
        rd(REG_EPC,      32'h8000_5000, "exl_epc_hold");
        entry(IsEret, 32'h0, 1'b0, 32'h8000_5000, "eret3_tgt");

        // Exception held by a 3-cycle stall, then a single commit
        exc.Break = 1'b1; EX_Entry_Sel = IsException; MEM_PC = 32'h8000_7000;
        MEM_IsInDelaySlot = 1'b0; MEM_Stall = 1'b1; CP0_RdAddr = REG_EPC;
        for (int i = 0; i < 3; i++) begin
            push(K_TGT, 32'h8000_0180, "stall_tgt");
            push(K_RD,  32'h8000_5000, "stall_epc");
            push(K_EXL, 32'h0,         "stall_exl");
            tick();
        end
        MEM_Stall = 1'b0;
        push(K_TGT, 32'h8000_0180, "commit_tgt");
        tick();
        idle();
        rd(REG_EPC,    32'h8000_7000, "commit_epc");
        rd(REG_CAUSE,  32'h0000_0024, "commit_cause");
        rd(REG_STATUS, 32'h0000_0002, "commit_status");
        entry(IsEret, 32'h0, 1'b0, 32'h8000_7000, "eret4_tgt");

        entry(IsRefetch, 32'h8000_8000, 1'b0, 32'h8000_8004, "refetch_tgt");
        push(K_TGT, 32'h0, "none_tgt");
        rd(REG_STATUS, 32'h0, "refetch_status");

        mtc0(REG_CAUSE, 32'hFFFF_FFFF);
        rd(REG_CAUSE, 32'h0000_0324, "cause_ip10");

        // Reset in the middle of a run
        mtc0(REG_COUNT, 32'd5);
        rd(REG_COUNT, 32'd5, "count_wr");
        rst = 1'b0;
        rd(REG_COUNT,  32'h0,         "mid_rst_count");
        rd(REG_STATUS, 32'h0040_0000, "mid_rst_status");
        rd(REG_EPC,    32'h0,         "mid_rst_epc");
        rd(REG_CAUSE,  32'h0,         "mid_rst_cause");

        // Timer from a known divider phase: Compare=3, Count starts at 0
        rst = 1'b1;
        MEM_CP0We = 1'b1; MEM_CP0Addr = REG_COMPARE; MEM_CP0Wdata = 32'd3;
        CP0_RdAddr = REG_COUNT;
        push(K_RD, 32'd0, "rel_count");
        tick();
        MEM_CP0We = 1'b0;
        push(K_RD, 32'd0, "c1_count");
        tick();
        push(K_RD, 32'd1, "c2_count");
        repeat (4) tick();
        push(K_RD, 32'd3,  "ti_count");
        push(K_IP, 32'h0,  "ip7_pre");
        tick();
        push(K_IP, 32'h20, "ip7_set");
        tick();
        push(K_IP, 32'h20, "ip7_sticky");
        mtc0(REG_COMPARE, 32'h100);
        push(K_IP, 32'h20, "ip7_lag");
        tick();
        push(K_IP, 32'h0, "ip7_clr");
        rd(REG_COMPARE, 32'h100, "cmp_wr");
        Ext_Int = 6'h15;
        tick();
        push(K_IP, 32'h15, "ext_ip");
        Ext_Int = 6'h00;
        tick();
        push(K_IP, 32'h0, "ext_ip_clr");
        tick();
        tick();

        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %0s unchecked want=%h", e.name, e.v);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
